// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encoding.
package pipe_ctrl_pkg;

  // Encoding 2'd3 is unused; the FSM treats it as RUN and returns there.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in ID_EX whose destination feeds an ID source.
module load_use_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);

  // x0 is never a real dependency, so a load to x0 never stalls.
  always_comb begin
    hazard = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-wait stalls
// with a sticky timeout fault. Optional performance counters are built only when
// HAZARD_PERF_CNT_EN is defined; otherwise stall_cnt/flush_cnt read as zero.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] WaitMaxC = CNT_W'(WAIT_MAX);

  hz_state_e        state_q;
  logic [CNT_W-1:0] wait_q;
  logic             fault_q;
  logic             load_use;
  logic             run_eval;

  load_use_detect u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .hazard     (load_use)
  );

  // FSM: state, wait counter and sticky fault; FAULT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (!mem_busy) begin
            state_q <= ST_RUN;
          end else if (wait_q >= WaitMaxC) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          if (mem_busy) begin
            state_q <= ST_WAIT;
            wait_q  <= '0;
          end else begin
            state_q <= ST_RUN;
          end
        end
      endcase
    end
  end

  // Enables and flushes: reset forces the quiet RUN pattern; the WAIT exit cycle
  // is decoded exactly like RUN.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    run_eval    = 1'b1;
    case (state_q)
      ST_WAIT:  run_eval = !mem_busy;
      ST_FAULT: run_eval = 1'b0;
      default:  run_eval = 1'b1;
    endcase
    if (rst_n) begin
      if (!run_eval || mem_busy) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign state = state_q;
  assign fault = fault_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating event counters for stalled and flushed cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PerfEn = 1;
`else
  localparam int unsigned PerfEn = 0;
`endif

  // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush}
  localparam logic [4:0] CtlNormal  = 5'b11100;
  localparam logic [4:0] CtlStall   = 5'b00000;
  localparam logic [4:0] CtlBranch  = 5'b11111;
  localparam logic [4:0] CtlLoadUse = 5'b00101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_memread, ex_branch_taken, mem_busy;
  logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush;
  logic [1:0]  state;
  logic        fault;
  logic [15:0] stall_cnt, flush_cnt;
  logic [4:0]  ctl;

  int n_assert = 0;
  int n_fail   = 0;

  assign ctl = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush};

  hazard_ctrl #(
    .WAIT_MAX (15),
    .CNT_W    (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .state           (state),
    .fault           (fault),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive the inputs for the new cycle.
  task automatic cyc(input logic busy, input logic br, input logic mr,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clk);
    #1;
    mem_busy        = busy;
    ex_branch_taken = br;
    ex_memread      = mr;
    ex_rd           = rd;
    id_rs1          = rs1;
    id_rs2          = rs2;
    #1;
  endtask

  // Mid-cycle reset pulse with hazard-provoking inputs held during reset.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n           = 1'b0;
    mem_busy        = 1'b1;
    ex_branch_taken = 1'b1;
    ex_memread      = 1'b1;
    ex_rd           = 5'd4;
    id_rs1          = 5'd4;
    id_rs2          = 5'd4;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(CtlNormal));
    @(posedge clk);
    #1;
    mem_busy        = 1'b0;
    ex_branch_taken = 1'b0;
    ex_memread      = 1'b0;
    ex_rd           = 5'd0;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    rst_n           = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b1;
    mem_busy        = 1'b1;
    ex_branch_taken = 1'b1;
    ex_memread      = 1'b1;
    ex_rd           = 5'd5;
    id_rs1          = 5'd5;
    id_rs2          = 5'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("por_state", 32'(state), 32'd0);
    chk("por_fault", 32'(fault), 32'd0);
    chk("por_ctl", 32'(ctl), 32'(CtlNormal));
    chk("por_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("por_flush_cnt", 32'(flush_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("por_hold_state", 32'(state), 32'd0);
    chk("por_hold_ctl", 32'(ctl), 32'(CtlNormal));
    mem_busy = 1'b0; ex_branch_taken = 1'b0; ex_memread = 1'b0;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(CtlNormal));

    // Load-use on rs2 stalls exactly one cycle.
    cyc(1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5);
    chk("lu_rs2_ctl", 32'(ctl), 32'(CtlLoadUse));
    cyc(1'b0, 1'b0, 1'b0, 5'd5, 5'd3, 5'd5);
    chk("lu_once_ctl", 32'(ctl), 32'(CtlNormal));
    chk("lu_once_state", 32'(state), 32'd0);
    // Load to x0 is not a hazard.
    cyc(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("x0_ctl", 32'(ctl), 32'(CtlNormal));
    cyc(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2);
    chk("lu_rs1_ctl", 32'(ctl), 32'(CtlLoadUse));
    cyc(1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd2);
    chk("no_load_ctl", 32'(ctl), 32'(CtlNormal));
    // Branch beats load-use.
    cyc(1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd2);
    chk("br_over_lu_ctl", 32'(ctl), 32'(CtlBranch));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("br_flush_cnt", 32'(flush_cnt), 32'(PerfEn));
    chk("lu_stall_cnt", 32'(stall_cnt), 32'(2 * PerfEn));
    // Busy beats branch and load-use.
    cyc(1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 5'd2);
    chk("busy_prio_ctl", 32'(ctl), 32'(CtlStall));
    chk("busy_prio_state", 32'(state), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("wait_entered", 32'(state), 32'd1);
    // Reset in the middle of WAIT.
    pulse_reset();
    #1;
    chk("post_rst_wait_state", 32'(state), 32'd0);

    // Busy for three cycles, then released with a branch.
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("w_a_ctl", 32'(ctl), 32'(CtlStall));
    chk("w_a_state", 32'(state), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("w_b_ctl", 32'(ctl), 32'(CtlStall));
    chk("w_b_state", 32'(state), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("w_c_ctl", 32'(ctl), 32'(CtlStall));
    chk("w_c_state", 32'(state), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("w_exit_ctl", 32'(ctl), 32'(CtlBranch));
    chk("w_exit_state", 32'(state), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("w_run_ctl", 32'(ctl), 32'(CtlNormal));
    chk("w_run_state", 32'(state), 32'd0);
    chk("w_stall_cnt", 32'(stall_cnt), 32'(3 * PerfEn));
    chk("w_flush_cnt", 32'(flush_cnt), 32'(PerfEn));

    // Timeout: busy held 20 cycles; FAULT first seen on cycle 18.
    pulse_reset();
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      if (i == 17) begin
        chk("to_c17_state", 32'(state), 32'd1);
        chk("to_c17_fault", 32'(fault), 32'd0);
      end
      if (i == 18) begin
        chk("to_c18_state", 32'(state), 32'd2);
        chk("to_c18_fault", 32'(fault), 32'd1);
      end
      if (i == 20) chk("to_c20_ctl", 32'(ctl), 32'(CtlStall));
    end
    cyc(1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7);
    chk("fault_hold_state", 32'(state), 32'd2);
    chk("fault_hold_fault", 32'(fault), 32'd1);
    chk("fault_hold_ctl", 32'(ctl), 32'(CtlStall));
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("fault_late_state", 32'(state), 32'd2);
    chk("fault_stall_cnt", 32'(stall_cnt), 32'(22 * PerfEn));
    pulse_reset();
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("fault_clr_state", 32'(state), 32'd0);
    chk("fault_clr_fault", 32'(fault), 32'd0);
    chk("fault_clr_ctl", 32'(ctl), 32'(CtlNormal));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter: WAIT_MAX, default 15, memory-wait cycles before timeout fault.
REQ-002 SHALL provide parameter: CNT_W, default 16, width of the wait counter and the performance counters.
REQ-003 SHALL have ports, clock and reset first: clk in 1, single clock; rst_n in 1, reset.
REQ-004 SHALL state as decided: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: id_rs1 in 5, ID source 1; id_rs2 in 5, ID source 2.
REQ-006 SHALL have ports: ex_rd in 5, ID_EX destination; ex_memread in 1, ID_EX load flag.
REQ-007 SHALL have ports: ex_branch_taken in 1, branch resolved taken in EX; mem_busy in 1, data memory not ready.
REQ-008 SHALL have ports: pc_write out 1; if_id_write out 1; id_ex_write out 1; if_id_flush out 1; id_ex_flush out 1 (zero ID_EX control bits).
REQ-009 SHALL have ports: state out 2; fault out 1, sticky timeout; stall_cnt out CNT_W; flush_cnt out CNT_W.

Function
REQ-010 SHALL implement FSM states RUN=0, WAIT=1, FAULT=2; encoding 3 unused, recovers to RUN.
REQ-011 SHALL define load-use hazard: ex_memread=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2.
REQ-012 SHALL, in RUN with mem_busy=1: deassert all three write enables in that cycle, no flushes, next state WAIT, clear wait counter.
REQ-013 SHALL, in RUN with mem_busy=0 and ex_branch_taken=1: assert if_id_flush and id_ex_flush, all write enables 1, same cycle.
REQ-014 SHALL, in RUN with no busy, no branch, load-use hazard: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, same cycle (one bubble).
REQ-015 SHALL, in RUN with no event: all write enables 1, both flushes 0.
REQ-016 SHALL apply priority mem_busy > ex_branch_taken > load-use.
REQ-017 SHALL, in WAIT: hold all write enables 0, flushes 0, increment wait counter each cycle busy stays 1.
REQ-018 SHALL leave WAIT for RUN on the first cycle mem_busy=0; that cycle is evaluated as RUN (REQ-013..015).
REQ-019 SHALL enter FAULT when wait counter reaches WAIT_MAX with mem_busy still 1; set fault=1.
REQ-020 SHALL, in FAULT: all write enables 0, flushes 0; exit only by reset; fault remains 1.
REQ-021 SHALL saturate the wait counter at WAIT_MAX; no wrap.
REQ-022 SHALL register state, wait counter, fault and counters only; enables and flushes are combinational from state and inputs.

Reset
REQ-023 SHALL, on rst_n=0 asynchronously: state=RUN, wait counter=0, fault=0, stall_cnt=0, flush_cnt=0.
REQ-024 SHALL, during reset: pc_write=if_id_write=id_ex_write=1, flushes=0 (RUN, no event assumed by inputs-independent override).
REQ-025 SHALL abandon any WAIT or FAULT on reset mid-operation; first cycle after release is RUN.

Configuration
REQ-026 SHALL honour macro HAZARD_PERF_CNT_EN.
REQ-027 SHALL, with HAZARD_PERF_CNT_EN defined: stall_cnt +1 each cycle pc_write=0; flush_cnt +1 each cycle if_id_flush=1; both saturate at all-ones.
REQ-028 SHALL, without HAZARD_PERF_CNT_EN: stall_cnt and flush_cnt tied to 0, no counter flops; ports retained.

Structure
REQ-029 SHALL place state encoding constants (ST_RUN, ST_WAIT, ST_FAULT) in shared package pipe_ctrl_pkg.
REQ-030 SHALL implement load-use compare as sub-module load_use_detect (combinational, 1-bit hazard out).
REQ-031 SHALL fit in 120-400 RTL lines; no other sub-modules.

Verification
REQ-032 SHALL cover: ex_memread=1, ex_rd=5, id_rs2=5, RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle.
REQ-033 SHALL cover: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall, all enables 1.
REQ-034 SHALL cover: ex_branch_taken=1 with load-use hazard same cycle -> both flushes 1, pc_write=1, flush_cnt +1.
REQ-035 SHALL cover: mem_busy high 3 cycles then low -> state WAIT 3 cycles, enables 0 for 3 cycles, RUN on 4th, stall_cnt=3.
REQ-036 SHALL cover: mem_busy held 20 cycles, WAIT_MAX=15 -> fault=1, state=FAULT, stays after busy drops until rst_n=0.
REQ-037 SHALL cover: rst_n pulsed low during WAIT -> immediate state=RUN, counters 0, fault 0.
